coin_acceptor: RTL
==================

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 SHALL have parameter FARE, default 4, meaning the amount debited per charge (range 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 12, meaning the idle cycles in COLLECT before the balance is refunded (range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port coin_valid, input, 1 bit: one-cycle strobe, a coin was inserted.
REQ-006 SHALL have port coin_value, input, 2 bits: coin denomination, sampled with coin_valid (00=1, 01=2, 10=5, 11=10).
REQ-007 SHALL have port card, input, 1 bit: level, passenger presents at the gate.
REQ-008 SHALL have port charge, input, 1 bit: one-cycle strobe from the downstream gate FSM requesting a fare debit.
REQ-009 SHALL have port run, output, 1 bit: registered; feeds the downstream gate FSM run input.
REQ-010 SHALL have port balance, output, 4 bits: registered; feeds the downstream gate FSM balance input.
REQ-011 SHALL have port err, output, 1 bit: registered one-cycle pulse for a rejected coin, an overflow, or insufficient funds.

Function
REQ-012 SHALL implement the FSM states IDLE=0, COLLECT=1, ARMED=2, DEBIT=3, and SHALL send any other encoding to IDLE on the next clock.
REQ-013 In IDLE, SHALL hold balance=0 and run=0; on coin_valid SHALL add the denomination and enter COLLECT; card SHALL be ignored.
REQ-014 In COLLECT, on coin_valid, SHALL set balance to min(balance+value, 15), clear the idle timer, and pulse err for one cycle when the sum exceeds 15.
REQ-015 In COLLECT, SHALL increment a 4-bit idle timer on every cycle without coin_valid.
REQ-016 In COLLECT, when the idle timer reaches TIMEOUT, SHALL clear balance to 0, clear the timer, and enter IDLE on that edge.
REQ-017 In COLLECT, when coin_valid and the timer reaching TIMEOUT occur in the same cycle, the coin SHALL win: the coin is added and the timer is cleared.
REQ-018 In COLLECT, with card=1 and no coin_valid, SHALL enter ARMED, with run=1 on the next cycle.
REQ-019 In COLLECT, when coin_valid and card coincide, SHALL add the coin and stay in COLLECT; ARMED is entered the following cycle if card is still 1.
REQ-020 In ARMED, SHALL hold run=1, freeze balance, and hold the idle timer at 0.
REQ-021 In ARMED, coin_valid SHALL be rejected: the coin is not added and err pulses for one cycle.
REQ-022 In ARMED, on card=0, SHALL return to COLLECT, with run=0 on the next cycle.
REQ-023 In ARMED, when charge=1, SHALL enter DEBIT; charge SHALL win over a simultaneous card=0.
REQ-024 In DEBIT (exactly one cycle), SHALL drive run=0.
REQ-025 In DEBIT, if balance>=FARE, SHALL set balance=balance-FARE; otherwise balance SHALL be unchanged and err SHALL pulse.
REQ-026 On leaving DEBIT, SHALL go to IDLE if the resulting balance is 0, else to COLLECT with the timer cleared.
REQ-027 SHALL ignore charge outside ARMED.
REQ-028 SHALL give a charge-to-balance-update latency of 2 edges: ARMED->DEBIT, then DEBIT->next state.
REQ-029 SHALL perform all arithmetic at 5 bits internally and saturate to 4 bits; balance SHALL never wrap.

Reset
REQ-030 While reset=1, regardless of clk, SHALL force state=IDLE, balance=0, run=0, err=0, and idle timer=0.
REQ-031 When reset is asserted mid-operation, including in ARMED or DEBIT, SHALL discard any accumulated balance with no refund output.
REQ-032 After reset is released, SHALL process the first coin_valid on the first rising clock edge.

Verification
REQ-033 Bench SHALL cover: reset; coins 5,2 -> balance 5 then 7; card=1 -> run=1 on the next cycle; charge -> DEBIT, balance 3, state COLLECT, run=0.
REQ-034 Bench SHALL cover: coins 10,10 -> balance 15, err pulse on the second coin; 12 idle cycles -> balance 0, state IDLE.
REQ-035 Bench SHALL cover: balance 2, card=1, charge -> err pulse, balance stays 2, return to COLLECT.
REQ-036 Bench SHALL cover: balance 4, card=1, coin_valid in ARMED -> err pulse, balance 4; then charge together with card=0 -> balance 0, state IDLE.
REQ-037 Bench SHALL cover: idle timer at 11 of 12, coin value 1 in the same cycle as the timeout -> coin added, timer 0, no refund.
REQ-038 Bench SHALL cover: reset asserted asynchronously between clock edges while in ARMED with balance 9 -> run=0 and balance=0 immediately.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin acceptor: collects coins into a saturating 4-bit balance, arms the downstream
// gate on card presence, debits FARE on request, and refunds on idle timeout.
module coin_acceptor #(
    parameter int unsigned FARE    = 4,
    parameter int unsigned TIMEOUT = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_value,
    input  logic       card,
    input  logic       charge,
    output logic       run,
    output logic [3:0] balance,
    output logic       err
);

    localparam int unsigned BAL_W = 4;
    localparam int unsigned SUM_W = 5;
    localparam logic [SUM_W-1:0] BAL_MAX   = SUM_W'(15);
    localparam logic [SUM_W-1:0] FARE_S    = SUM_W'(FARE);
    localparam logic [BAL_W-1:0] FARE_B    = BAL_W'(FARE);
    localparam logic [SUM_W-1:0] TIMEOUT_S = SUM_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ARMED   = 2'd2,
        DEBIT   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [BAL_W-1:0]   balance_q, balance_d;
    logic [BAL_W-1:0]   timer_q, timer_d;
    logic               run_q, run_d;
    logic               err_q, err_d;

    logic [SUM_W-1:0]   coin_amt;
    logic [SUM_W-1:0]   coin_sum;
    logic [SUM_W-1:0]   timer_inc;
    logic [BAL_W-1:0]   debit_bal;

    // Denomination decode and 5-bit arithmetic helpers
    always_comb begin
        case (coin_value)
            2'b00:   coin_amt = SUM_W'(1);
            2'b01:   coin_amt = SUM_W'(2);
            2'b10:   coin_amt = SUM_W'(5);
            default: coin_amt = SUM_W'(10);
        endcase
        coin_sum  = {1'b0, balance_q} + coin_amt;
        timer_inc = {1'b0, timer_q} + SUM_W'(1);
        debit_bal = balance_q - FARE_B;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            balance_q <= '0;
            timer_q   <= '0;
            run_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            balance_q <= balance_d;
            timer_q   <= timer_d;
            run_q     <= run_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        balance_d = balance_q;
        timer_d   = timer_q;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                balance_d = '0;
                timer_d   = '0;
                if (coin_valid) begin
                    balance_d = BAL_W'(coin_amt);
                    state_d   = COLLECT;
                end
            end
            COLLECT: begin
                // A coin always beats both card and timeout in the same cycle
                if (coin_valid) begin
                    timer_d = '0;
                    if (coin_sum > BAL_MAX) begin
                        balance_d = BAL_W'(15);
                        err_d     = 1'b1;
                    end else begin
                        balance_d = coin_sum[BAL_W-1:0];
                    end
                end else if (card) begin
                    timer_d = '0;
                    state_d = ARMED;
                end else if (timer_inc == TIMEOUT_S) begin
                    balance_d = '0;
                    timer_d   = '0;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_inc[BAL_W-1:0];
                end
            end
            ARMED: begin
                timer_d = '0;
                err_d   = coin_valid;
                if (charge) begin
                    state_d = DEBIT;
                end else if (!card) begin
                    state_d = COLLECT;
                end
            end
            DEBIT: begin
                timer_d = '0;
                if ({1'b0, balance_q} >= FARE_S) begin
                    balance_d = debit_bal;
                    state_d   = (debit_bal == '0) ? IDLE : COLLECT;
                end else begin
                    err_d   = 1'b1;
                    state_d = (balance_q == '0) ? IDLE : COLLECT;
                end
            end
            default: begin
                state_d   = IDLE;
                balance_d = '0;
                timer_d   = '0;
            end
        endcase

        run_d = (state_d == ARMED);
    end

    assign run     = run_q;
    assign balance = balance_q;
    assign err     = err_q;

endmodule
